hw_saida_pulso: RTL and testbench
=================================

# hw_saida_pulso

Avalon-MM slave output port driving `out_port` toward board-level logic (LEDs, enables, strobes); the write-side counterpart of the team's read-only input port peripheral. Software writes a level register, atomically sets or clears individual bits, or fires a hardware-timed one-shot pulse that inverts selected bits for an exact number of clock cycles. Sits on the Nios II data master's Avalon fabric with a 2-bit word address, like the other PIO-style slaves in the system.

## Interface
- `DATA_WIDTH`, 8: width of `out_port` and the level register; legal range 1..16.
- `LEN_WIDTH`, 16: width of the pulse-length register and down-counter.
- `RESET_VALUE`, 0: reset value of the level register.

- `clk`  in  1  system clock; all logic on its rising edge.
- `reset_n`  in  1  reset, asynchronous assert, active-low; one clock, asynchronous active-low reset.
- `address`  in  2  word address of the register.
- `chipselect`  in  1  slave selected.
- `write_n`  in  1  active-low write strobe; qualifies with `chipselect`.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data.
- `out_port`  out  DATA_WIDTH  driven output = `data_q ^ mask_q`.

## Operation
- Register map:
  - 0 DATA: R/W. Write loads `data_q <= writedata[DATA_WIDTH-1:0]`.
  - 1 PULSE_LEN: R/W. Write loads `len_q <= writedata[LEN_WIDTH-1:0]`.
  - 2 PULSE: write fires a pulse. Read returns `{busy at bit 16, mask_q at [DATA_WIDTH-1:0]}`, all other bits 0.
  - 3 SETCLR: write only. `data_q <= (data_q & ~writedata[15:0]) | writedata[31:16]`, truncated to DATA_WIDTH. Set wins over clear on the same bit. Reads return 0.
- The write strobe is `chipselect & ~write_n`. There is no wait-state and no byte enables; the whole word is written.
- Pulse engine states:
  - IDLE: `mask_q == 0`, `cnt_q == 0`, `busy = 0`.
  - ACTIVE: `cnt_q != 0`, `busy = 1`.
- Fire (write to address 2):
  - If `writedata[DATA_WIDTH-1:0] != 0` and `len_q != 0`: `mask_q <= writedata`, `cnt_q <= len_q`, state becomes ACTIVE.
  - Otherwise the write is ignored; state and any pulse in progress are unchanged.
- In ACTIVE, each cycle without a fire:
  - If `cnt_q == 1`: `cnt_q <= 0` and `mask_q <= 0`, returning to IDLE.
  - Otherwise: `cnt_q <= cnt_q - 1`.
- A fire while ACTIVE retriggers: the new mask replaces the old one and the count reloads. A fire in the same cycle as expiry wins over expiry.
- Writing PULSE_LEN during ACTIVE affects only later fires. Writing DATA or SETCLR during ACTIVE changes `out_port` immediately; the inversion still applies.
- Maximum pulse length is 2^LEN_WIDTH - 1 cycles. The counter never wraps.

## Timing
- Reset values: `readdata` 0, `data_q` RESET_VALUE, `len_q` 0, `mask_q` 0, `cnt_q` 0, therefore `out_port` = RESET_VALUE.
- Reset asserted mid-pulse ends the pulse immediately and asynchronously.
- Read latency is 1 cycle. `readdata` is registered every cycle from the current `address` with no dependency on `chipselect`, and returns pre-write register values on the edge of a write.
- Write latency is 0 cycles: a write sampled at edge k appears on `out_port` right after edge k.
- A fire at edge k with `len_q = N`:
  - the inversion is visible on `out_port` right after edge k;
  - it is removed right after edge k+N;
  - it lasts exactly N cycles.
- `busy` reads 1 when sampled during the cycles from k+1 through k+N-1 and 0 from k+N on.

## Test plan
- Reset to DATA=0x00 and PULSE_LEN=0. Write DATA=0xA5 → `out_port`=0xA5 after one edge. Read address 0 → `readdata`=0x000000A5 one cycle later.
- With DATA=0xA5, write SETCLR=0x0003_0081 → DATA=0x27. Write SETCLR=0x0001_0001 → bit 0 remains 1 (set wins).
- PULSE_LEN=5, DATA=0x00, fire 0x0F → `out_port`=0x0F for exactly 5 cycles, then 0x00. Reading PULSE mid-pulse → 0x0001000F.
- Fire with PULSE_LEN=0, and fire with a zero mask → `out_port` unchanged and `busy` stays 0.
- PULSE_LEN=4, fire 0x01, then fire 0x80 two cycles later → 0x01 for 2 cycles, then 0x80 for 4 cycles. Also fire 0x02 on the exact expiry cycle → the pulse continues with 0x02 for 4 more cycles, with no gap.
- PULSE_LEN=0xFFFF pulse with `reset_n` dropped mid-pulse → `out_port` = RESET_VALUE immediately and all registers read 0 after release. Also write DATA=0xF0 during a 0x0F pulse → `out_port`=0xFF until expiry, then 0xF0.

Source files
------------

// File: rtl/hw_saida_pulso_if.sv
// Avalon-MM slave bus for the pulse output port: word address, write strobe
// qualified by chipselect, and a registered 32-bit read path.
interface hw_saida_pulso_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );
endinterface

// File: rtl/hw_saida_pulso.sv
// PIO-style output port: level register with atomic set/clear plus a one-shot
// engine that inverts selected bits of out_port for an exact cycle count.
module hw_saida_pulso #(
  parameter int          DATA_WIDTH  = 8,
  parameter int          LEN_WIDTH   = 16,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  hw_saida_pulso_if.slave       avs,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam logic [DATA_WIDTH-1:0] RST_DATA = DATA_WIDTH'(RESET_VALUE);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic [DATA_WIDTH-1:0] mask_q,  mask_d;
  logic [LEN_WIDTH-1:0]  len_q,   len_d;
  logic [LEN_WIDTH-1:0]  cnt_q,   cnt_d;
  logic [31:0]           rd_q,    rd_d;

  logic                  wr_en;
  logic                  fire_ok;
  logic                  busy;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [15:0]           data_ext;
  logic [15:0]           setclr_val;

  assign wr_en      = avs.chipselect & ~avs.write_n;
  assign wr_data    = avs.writedata[DATA_WIDTH-1:0];
  assign busy       = (state_q == S_ACTIVE);
  assign data_ext   = 16'(data_q);
  // OR-ing the set field last makes set win over clear on the same bit.
  assign setclr_val = (data_ext & ~avs.writedata[15:0]) | avs.writedata[31:16];

  // A fire with an empty mask or zero length leaves any running pulse untouched.
  assign fire_ok = wr_en && (avs.address == 2'd2) &&
                   (wr_data != '0) && (len_q != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    if (fire_ok) begin
      state_d = S_ACTIVE;
      cnt_d   = len_q;
      mask_d  = wr_data;
    end else begin
      case (state_q)
        S_ACTIVE: begin
          if (cnt_q == LEN_WIDTH'(1)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            mask_d  = '0;
          end else begin
            cnt_d = cnt_q - LEN_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    data_d = data_q;
    len_d  = len_q;
    if (wr_en) begin
      case (avs.address)
        2'd0:    data_d = wr_data;
        2'd1:    len_d  = avs.writedata[LEN_WIDTH-1:0];
        2'd3:    data_d = setclr_val[DATA_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // Read mux ignores chipselect; pre-edge values are captured on a write edge.
  always_comb begin
    rd_d = '0;
    case (avs.address)
      2'd0: rd_d = 32'(data_q);
      2'd1: rd_d = 32'(len_q);
      2'd2: begin
        rd_d     = 32'(mask_q);
        rd_d[16] = busy;
      end
      default: rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      data_q  <= RST_DATA;
      mask_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

  assign avs.readdata = rd_q;
  assign out_port     = data_q ^ mask_q;

endmodule

// File: tb/tb_hw_saida_pulso.sv
// Bench for hw_saida_pulso: directed test-plan sequence with literal pins, then
// random bus traffic, all checked every cycle against a time-based pulse model.
module tb_hw_saida_pulso;

  localparam int DW     = 8;
  localparam int LW     = 16;
  localparam int RV     = 0;
  localparam longint PERIOD = 10;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b1;
  logic [DW-1:0] out_port;

  hw_saida_pulso_if bus ();

  hw_saida_pulso #(
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW),
    .RESET_VALUE(RV)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .avs     (bus),
    .out_port(out_port)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model: the pulse is a mask plus the absolute time of its last active edge
  // window; after an edge at time t the inversion applies iff t < m_end.
  int unsigned m_data;
  int unsigned m_len;
  int unsigned m_mask;
  longint      m_end;
  logic [31:0] m_rd;

  function automatic bit active_at(input longint edge_t);
    return (m_end != 0) && (edge_t < m_end);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    longint      t;
    bit          wr;
    int unsigned wd;
    if (!reset_n) begin
      m_data = RV;
      m_len  = 0;
      m_mask = 0;
      m_end  = 0;
      m_rd   = '0;
    end else begin
      t  = $time;
      wr = bus.chipselect && !bus.write_n;
      wd = bus.writedata;
      case (bus.address)
        2'd0: m_rd = m_data;
        2'd1: m_rd = m_len;
        2'd2: m_rd = active_at(t - PERIOD) ? (32'h1_0000 | m_mask) : 32'h0;
        default: m_rd = 32'h0;
      endcase
      if (wr) begin
        case (bus.address)
          2'd0: m_data = wd & 32'hFF;
          2'd1: m_len  = wd & 32'hFFFF;
          2'd2: if ((wd & 32'hFF) != 0 && m_len != 0) begin
                  m_mask = wd & 32'hFF;
                  m_end  = t + longint'(m_len) * PERIOD;
                end
          default: m_data = ((m_data & ~(wd & 32'hFFFF)) | (wd >> 16)) & 32'hFF;
        endcase
      end
    end
  end

  bit          pin_on = 1'b0;
  bit          pin_out_en;
  logic [7:0]  pin_out;
  bit          pin_rd_en;
  logic [31:0] pin_rd;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] exp_out;
    if (chk_en) begin
      exp_out = active_at($time - PERIOD / 2) ? (m_data ^ m_mask) : m_data;
      check("model_out_port", 32'(out_port), exp_out);
      check("model_readdata", bus.readdata, m_rd);
      if (pin_on && pin_out_en) check("pin_out_port", 32'(out_port), 32'(pin_out));
      if (pin_on && pin_rd_en)  check("pin_readdata", bus.readdata, pin_rd);
    end
  end

  task automatic pin(input bit oe, input logic [7:0] o, input bit re, input logic [31:0] r);
    pin_out_en = oe;
    pin_out    = o;
    pin_rd_en  = re;
    pin_rd     = r;
    pin_on     = 1'b1;
    @(negedge clk);
    #1 pin_on = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    $display("WR addr=%0d data=0x%08h out=0x%02h", a, d, out_port);
  endtask

  task automatic rd(input logic [1:0] a);
    bus.address = a;
    @(posedge clk);
    #1;
    $display("RD addr=%0d readdata=0x%08h", a, bus.readdata);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    idle(2);
    pin(1'b1, 8'h00, 1'b1, 32'h0);
    reset_n = 1'b1;

    rd(2'd1); pin(1'b1, 8'h00, 1'b1, 32'h0);
    wr(2'd0, 32'hA5); pin(1'b1, 8'hA5, 1'b0, 32'h0);
    rd(2'd0); pin(1'b1, 8'hA5, 1'b1, 32'h0000_00A5);

    wr(2'd3, 32'h0003_0081); pin(1'b1, 8'h27, 1'b0, 32'h0);
    wr(2'd3, 32'h0001_0001); pin(1'b1, 8'h27, 1'b0, 32'h0);
    rd(2'd3); pin(1'b1, 8'h27, 1'b1, 32'h0);

    // Basic 5-cycle pulse; the read at the first edge after the fire sees busy.
    wr(2'd1, 32'd5); wr(2'd0, 32'h0);
    wr(2'd2, 32'h0F); pin(1'b1, 8'h0F, 1'b0, 32'h0);
    rd(2'd2); pin(1'b1, 8'h0F, 1'b1, 32'h0001_000F);
    for (int i = 0; i < 3; i++) begin idle(1); pin(1'b1, 8'h0F, 1'b0, 32'h0); end
    idle(1); pin(1'b1, 8'h00, 1'b0, 32'h0);
    rd(2'd2); pin(1'b1, 8'h00, 1'b1, 32'h0);

    // Ignored fires: zero length, then zero mask.
    wr(2'd1, 32'd0); wr(2'd2, 32'h0F); pin(1'b1, 8'h00, 1'b0, 32'h0);
    rd(2'd2); pin(1'b1, 8'h00, 1'b1, 32'h0);
    wr(2'd1, 32'd4); wr(2'd2, 32'hFFFF_FF00); pin(1'b1, 8'h00, 1'b0, 32'h0);
    rd(2'd2); pin(1'b1, 8'h00, 1'b1, 32'h0);

    // Retrigger two cycles in, then a fire on the exact expiry edge.
    wr(2'd2, 32'h01); pin(1'b1, 8'h01, 1'b0, 32'h0);
    idle(1); pin(1'b1, 8'h01, 1'b0, 32'h0);
    wr(2'd2, 32'h80); pin(1'b1, 8'h80, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin idle(1); pin(1'b1, 8'h80, 1'b0, 32'h0); end
    idle(1); pin(1'b1, 8'h00, 1'b0, 32'h0);
    wr(2'd2, 32'h01);
    idle(3); pin(1'b1, 8'h01, 1'b0, 32'h0);
    wr(2'd2, 32'h02); pin(1'b1, 8'h02, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin idle(1); pin(1'b1, 8'h02, 1'b0, 32'h0); end
    idle(1); pin(1'b1, 8'h00, 1'b0, 32'h0);

    // Long pulse cut short by an asynchronous reset in mid-cycle.
    wr(2'd1, 32'hFFFF); wr(2'd0, 32'h0);
    wr(2'd2, 32'h0F); idle(10); pin(1'b1, 8'h0F, 1'b0, 32'h0);
    idle(1);
    #2 reset_n = 1'b0;
    #1 pin(1'b1, 8'h00, 1'b1, 32'h0);
    reset_n = 1'b1;
    rd(2'd0); pin(1'b1, 8'h00, 1'b1, 32'h0);
    rd(2'd1); pin(1'b1, 8'h00, 1'b1, 32'h0);
    rd(2'd2); pin(1'b1, 8'h00, 1'b1, 32'h0);

    // DATA written mid-pulse shows through the inversion until expiry.
    wr(2'd1, 32'd6);
    wr(2'd2, 32'h0F); wr(2'd0, 32'hF0); pin(1'b1, 8'hFF, 1'b0, 32'h0);
    idle(4); pin(1'b1, 8'hFF, 1'b0, 32'h0);
    idle(1); pin(1'b1, 8'hF0, 1'b0, 32'h0);

    // Random traffic, biased toward short pulses and frequent fires.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      #1;
      bus.address    = 2'($urandom_range(0, 3));
      bus.chipselect = ($urandom_range(0, 9) < 7);
      bus.write_n    = ($urandom_range(0, 9) < 5);
      case (bus.address)
        2'd1:    bus.writedata = ($urandom_range(0, 19) == 0) ? 32'd0 : 32'($urandom_range(1, 12));
        2'd2:    bus.writedata = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_FF00) : $urandom;
        default: bus.writedata = $urandom;
      endcase
      if ($urandom_range(0, 499) == 0) begin
        reset_n = 1'b0;
        @(negedge clk);
        #1 reset_n = 1'b1;
      end
    end
    @(negedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    idle(3);
    @(negedge clk);
    #1 chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
